// File: rtl/cf_math_pkg.sv
// Common math helpers for index sizing.
package cf_math_pkg;

  // Bits needed to index num_idx items (at least one bit)
  function automatic integer unsigned idx_width(input integer unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/fpnew_divsqrt_lane_arbiter_pkg.sv
// Defaults and index helpers for the DIV/SQRT lane arbiter.
package fpnew_divsqrt_lane_arbiter_pkg;

  localparam int unsigned DefaultNumLanes    = 4;
  localparam int unsigned DefaultWidth       = 64;
  localparam int unsigned DefaultMaxInFlight = 2;

  // (idx + off) modulo n, used for round-robin search and pointer advance
  function automatic int unsigned wrap_add(input int unsigned idx, input int unsigned off,
                                           input int unsigned n);
    return (idx + off) % n;
  endfunction

endpackage

// File: rtl/fpnew_pkg.sv
// Floating-point unit shared types used by the DIV/SQRT lane arbiter.
package fpnew_pkg;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpnew_divsqrt_id_fifo.sv
// In-flight lane index FIFO: remembers which lane owns each op inside the slice.
module fpnew_divsqrt_id_fifo #(
  parameter int unsigned Depth     = 2,
  parameter int unsigned DataWidth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] head_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrWidth = cf_math_pkg::idx_width(Depth);
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 do_push, do_pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  // Full comes from the registered count only: a same-cycle pop never frees a slot
  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; flush behaves like reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fpnew_divsqrt_lane_arbiter.sv
// Round-robin sharing of one multi-cycle DIV/SQRT slice between several lanes,
// with in-order result routing back to the issuing lane.
module fpnew_divsqrt_lane_arbiter
  import fpnew_pkg::*;
  import fpnew_divsqrt_lane_arbiter_pkg::*;
#(
  parameter int unsigned NumLanes    = DefaultNumLanes,
  parameter int unsigned Width       = DefaultWidth,
  parameter int unsigned MaxInFlight = DefaultMaxInFlight,
  parameter type         TagType     = logic
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumLanes-1:0]                lane_valid_i,
  output logic [NumLanes-1:0]                lane_ready_o,
  input  logic [NumLanes-1:0][1:0][Width-1:0] lane_operands_i,
  input  operation_e [NumLanes-1:0]          lane_op_i,
  input  fp_format_e [NumLanes-1:0]          lane_fmt_i,
  input  roundmode_e [NumLanes-1:0]          lane_rnd_i,
  input  TagType [NumLanes-1:0]              lane_tag_i,
  output logic                               unit_valid_o,
  input  logic                               unit_ready_i,
  output logic [1:0][Width-1:0]              unit_operands_o,
  output operation_e                         unit_op_o,
  output fp_format_e                         unit_fmt_o,
  output roundmode_e                         unit_rnd_o,
  output TagType                             unit_tag_o,
  input  logic                               unit_out_valid_i,
  output logic                               unit_out_ready_o,
  input  logic [Width-1:0]                   unit_result_i,
  input  status_t                            unit_status_i,
  input  TagType                             unit_tag_i,
  output logic [NumLanes-1:0]                lane_out_valid_o,
  input  logic [NumLanes-1:0]                lane_out_ready_i,
  output logic [Width-1:0]                   lane_result_o,
  output status_t                            lane_status_o,
  output TagType                             lane_tag_o,
  input  logic                               flush_i,
  output logic                               unit_flush_o,
  output logic                               busy_o
);

  localparam int unsigned IdxWidth = cf_math_pkg::idx_width(NumLanes);

  logic [IdxWidth-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0] arb_idx, cand_idx, winner, head;
  logic                lock_q, lock_d, found, run, issue, full, empty, pop;

  // Reset and flush both silence every handshake
  assign run = rst_ni & ~flush_i;

  // First requesting lane at or after the round-robin pointer
  always_comb begin
    arb_idx  = rr_q;
    cand_idx = rr_q;
    found    = 1'b0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      cand_idx = IdxWidth'(wrap_add(32'(rr_q), i, NumLanes));
      if (!found && lane_valid_i[cand_idx]) begin
        arb_idx = cand_idx;
        found   = 1'b1;
      end
    end
  end

  // A stalled issue keeps its winner so the slice sees stable fields
  assign winner       = lock_q ? lock_idx_q : arb_idx;
  assign unit_valid_o = (|lane_valid_i) & ~full & run;
  assign issue        = unit_valid_o & unit_ready_i;

  assign unit_operands_o = lane_operands_i[winner];
  assign unit_op_o       = lane_op_i[winner];
  assign unit_fmt_o      = lane_fmt_i[winner];
  assign unit_rnd_o      = lane_rnd_i[winner];
  assign unit_tag_o      = lane_tag_i[winner];
  assign unit_flush_o    = flush_i;

  // Zero-latency issue acknowledge to the winning lane
  always_comb begin
    lane_ready_o = '0;
    if (issue) lane_ready_o[winner] = 1'b1;
  end

  // Next pointer and lock state
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      lock_d = 1'b0;
    end else if (issue) begin
      rr_d   = IdxWidth'(wrap_add(32'(winner), 1, NumLanes));
      lock_d = 1'b0;
    end else if (unit_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end
  end

  // Pointer and lock registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  fpnew_divsqrt_id_fifo #(
    .Depth     (MaxInFlight),
    .DataWidth (IdxWidth)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (issue),
    .data_i  (winner),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Results with no owner (empty FIFO, flush, reset) are accepted and dropped
  assign unit_out_ready_o = (empty | ~run) ? 1'b1 : lane_out_ready_i[head];
  assign pop              = unit_out_valid_i & ~empty & run & lane_out_ready_i[head];
  assign lane_result_o    = unit_result_i;
  assign lane_status_o    = unit_status_i;
  assign lane_tag_o       = unit_tag_i;
  assign busy_o           = (|lane_valid_i) | ~empty;

  // Route the returning result to the lane at the FIFO head
  always_comb begin
    lane_out_valid_o = '0;
    if (unit_out_valid_i && !empty && run) lane_out_valid_o[head] = 1'b1;
  end

`ifndef SYNTHESIS
  // Flag results arriving while nothing is in flight
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      assert (!(unit_out_valid_i && empty))
        else $warning("slice result with no owning lane was drained");
    end
  end
`endif

endmodule

// File: tb/tb_fpnew_divsqrt_lane_arbiter.sv
// Directed bench for the DIV/SQRT lane arbiter with an issue-order scoreboard.
module tb_fpnew_divsqrt_lane_arbiter;
  import fpnew_pkg::*;

  localparam int unsigned NL  = 4;
  localparam int unsigned W   = 64;
  localparam int unsigned MIF = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [NL-1:0] lane_valid, lane_ready, lane_out_valid, lane_out_ready;
  logic [NL-1:0][1:0][W-1:0] lane_operands;
  operation_e [NL-1:0] lane_op;
  fp_format_e [NL-1:0] lane_fmt;
  roundmode_e [NL-1:0] lane_rnd;
  logic [NL-1:0] lane_tag;
  logic unit_valid, unit_ready;
  logic [1:0][W-1:0] unit_operands;
  operation_e unit_op;
  fp_format_e unit_fmt;
  roundmode_e unit_rnd;
  logic unit_tag;
  logic unit_out_valid, unit_out_ready;
  logic [W-1:0] unit_result, lane_result;
  status_t unit_status, lane_status;
  logic unit_tag_in, lane_tag_out;
  logic flush, unit_flush, busy;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned sb[$];

  always #5 clk = ~clk;

  fpnew_divsqrt_lane_arbiter #(
    .NumLanes (NL), .Width (W), .MaxInFlight (MIF), .TagType (logic)
  ) dut (
    .clk_i (clk), .rst_ni (rst_n),
    .lane_valid_i (lane_valid), .lane_ready_o (lane_ready),
    .lane_operands_i (lane_operands), .lane_op_i (lane_op),
    .lane_fmt_i (lane_fmt), .lane_rnd_i (lane_rnd), .lane_tag_i (lane_tag),
    .unit_valid_o (unit_valid), .unit_ready_i (unit_ready),
    .unit_operands_o (unit_operands), .unit_op_o (unit_op),
    .unit_fmt_o (unit_fmt), .unit_rnd_o (unit_rnd), .unit_tag_o (unit_tag),
    .unit_out_valid_i (unit_out_valid), .unit_out_ready_o (unit_out_ready),
    .unit_result_i (unit_result), .unit_status_i (unit_status), .unit_tag_i (unit_tag_in),
    .lane_out_valid_o (lane_out_valid), .lane_out_ready_i (lane_out_ready),
    .lane_result_o (lane_result), .lane_status_o (lane_status), .lane_tag_o (lane_tag_out),
    .flush_i (flush), .unit_flush_o (unit_flush), .busy_o (busy)
  );

  function automatic logic [127:0] opnd(input int unsigned l);
    return {64'hDEAD_0000_0000_0000 | 64'(l), 64'hBEEF_0000_0000_0000 | 64'(l + 4)};
  endfunction

  function automatic logic [W-1:0] res(input int unsigned l);
    return 64'hC0DE_0000_0000_0000 | 64'(l);
  endfunction

  function automatic logic [NL-1:0] onehot(input int unsigned l);
    return NL'(1) << l;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present the scoreboard head's result and check it lands on the right lane
  task automatic return_one(input string tag);
    int unsigned l;
    check({tag, "_pending"}, 128'(sb.size() != 0), 128'(1));
    if (sb.size() != 0) begin
      l = sb.pop_front();
      unit_out_valid = 1'b1;
      unit_result    = res(l);
      unit_tag_in    = 1'(l);
      #1;
      check({tag, "_lane_out_valid"}, 128'(lane_out_valid), 128'(onehot(l)));
      check({tag, "_result"}, 128'(lane_result), 128'(res(l)));
      check({tag, "_tag"}, 128'(lane_tag_out), 128'(1'(l)));
      check({tag, "_unit_out_ready"}, 128'(unit_out_ready), 128'(1));
    end
  endtask

  initial begin
    int exp_order[5];
    int ready_cnt[NL];
    int unsigned l;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    for (int i = 0; i < int'(NL); i++) ready_cnt[i] = 0;

    rst_n = 1'b0; lane_valid = '0; unit_ready = 1'b0; unit_out_valid = 1'b0;
    unit_result = '0; unit_status = '0; unit_tag_in = 1'b0; lane_out_ready = '1; flush = 1'b0;
    for (int i = 0; i < int'(NL); i++) begin
      lane_operands[i] = opnd(i);
      lane_op[i]  = (i % 2 == 1) ? SQRT : DIV;
      lane_fmt[i] = FP64;
      lane_rnd[i] = RNE;
      lane_tag[i] = 1'(i);
    end

    // Reset: outputs quiet even with requests and a stray result present
    tick(); tick();
    lane_valid = 4'hF; unit_out_valid = 1'b1; #1;
    check("rst_unit_valid", 128'(unit_valid), 128'(0));
    check("rst_lane_ready", 128'(lane_ready), 128'(0));
    check("rst_lane_out_valid", 128'(lane_out_valid), 128'(0));
    check("rst_unit_out_ready", 128'(unit_out_ready), 128'(1));
    lane_valid = '0; unit_out_valid = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_unit_valid", 128'(unit_valid), 128'(0));
    tick();

    // Lock: lane 2 stalls, lane 0 joins at cycle 2 but must not steal the issue
    for (int c = 0; c < 5; c++) begin
      lane_valid = (c >= 2) ? 4'b0101 : 4'b0100; unit_ready = 1'b0; #1;
      check("lock_unit_valid", 128'(unit_valid), 128'(1));
      check("lock_operands", 128'(unit_operands), opnd(2));
      check("lock_op", 128'(unit_op), 128'(DIV));
      check("lock_lane_ready", 128'(lane_ready), 128'(0));
      tick();
    end
    unit_ready = 1'b1; #1;
    check("lock_issue2", 128'(lane_ready), 128'(4'b0100));
    sb.push_back(2);
    tick();
    lane_valid = 4'b0001; #1;
    check("lock_issue0", 128'(lane_ready), 128'(4'b0001));
    check("lock_issue0_operands", 128'(unit_operands), opnd(0));
    sb.push_back(0);
    tick();
    lane_valid = '0; unit_ready = 1'b0;
    unit_status = status_t'(5'b00101);
    return_one("drain_a");
    check("drain_status", 128'(lane_status), 128'(5'b00101));
    tick();
    return_one("drain_b");
    tick();
    unit_out_valid = 1'b0; unit_status = '0;

    // Fill to MaxInFlight with lanes 1 then 3, then lane 0 must wait
    lane_valid = 4'b1010; unit_ready = 1'b1; #1;
    check("fill_issue1", 128'(lane_ready), 128'(4'b0010));
    check("fill_operands1", 128'(unit_operands), opnd(1));
    sb.push_back(1);
    tick();
    #1;
    check("fill_issue3", 128'(lane_ready), 128'(4'b1000));
    sb.push_back(3);
    tick();
    lane_valid = 4'b0001; #1;
    check("full_unit_valid", 128'(unit_valid), 128'(0));
    check("full_lane_ready", 128'(lane_ready), 128'(0));
    check("full_busy", 128'(busy), 128'(1));

    // Lane 1 back-pressures its result; lane 3 must not see a valid
    unit_out_valid = 1'b1; unit_result = res(1); unit_tag_in = 1'b1; lane_out_ready = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_lane_out_valid", 128'(lane_out_valid), 128'(onehot(sb[0])));
      check("bp_unit_out_ready", 128'(unit_out_ready), 128'(0));
      check("bp_unit_valid", 128'(unit_valid), 128'(0));
      tick();
    end
    lane_out_ready = '1; #1;
    check("pop1_lane_out_valid", 128'(lane_out_valid), 128'(onehot(sb[0])));
    check("pop1_unit_out_ready", 128'(unit_out_ready), 128'(1));
    check("pop1_no_bypass", 128'(unit_valid), 128'(0));
    l = sb.pop_front();
    tick();
    unit_result = res(3); unit_tag_in = 1'b1; #1;
    check("pop3_lane_out_valid", 128'(lane_out_valid), 128'(onehot(sb[0])));
    check("pop3_result", 128'(lane_result), 128'(res(3)));
    check("pushpop_issue0", 128'(lane_ready), 128'(4'b0001));
    l = sb.pop_front();
    sb.push_back(0);
    tick();

    // Flush with two ops in flight
    unit_out_valid = 1'b0; lane_valid = 4'b0010; #1;
    check("pre_flush_issue1", 128'(lane_ready), 128'(4'b0010));
    sb.push_back(1);
    tick();
    flush = 1'b1; lane_valid = 4'b0100; unit_out_valid = 1'b1; unit_result = res(0); #1;
    check("flush_unit_valid", 128'(unit_valid), 128'(0));
    check("flush_lane_ready", 128'(lane_ready), 128'(0));
    check("flush_lane_out_valid", 128'(lane_out_valid), 128'(0));
    check("flush_fwd", 128'(unit_flush), 128'(1));
    check("flush_unit_out_ready", 128'(unit_out_ready), 128'(1));
    sb.delete();
    tick();
    flush = 1'b0; lane_valid = '0; unit_out_valid = 1'b1; #1;
    check("post_flush_busy", 128'(busy), 128'(0));
    check("spurious_lane_out_valid", 128'(lane_out_valid), 128'(0));
    check("spurious_drain", 128'(unit_out_ready), 128'(1));
    tick();
    unit_out_valid = 1'b0; lane_valid = 4'b1001; unit_ready = 1'b0; #1;
    check("rr_kept_valid", 128'(unit_valid), 128'(1));
    check("rr_kept_winner3", 128'(unit_operands), opnd(3));
    tick();

    // Reset mid-issue while lane 3 holds the lock
    rst_n = 1'b0; #1;
    check("midrst_unit_valid", 128'(unit_valid), 128'(0));
    check("midrst_lane_ready", 128'(lane_ready), 128'(0));
    check("midrst_lane_out_valid", 128'(lane_out_valid), 128'(0));
    tick();
    rst_n = 1'b1; #1;
    check("midrst_winner0", 128'(unit_operands), opnd(0));
    check("midrst_op0", 128'(unit_op), 128'(DIV));

    // All lanes requesting, slice always ready, results one cycle later
    lane_valid = 4'hF; unit_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        l = sb.pop_front();
        unit_out_valid = 1'b1; unit_result = res(l); unit_tag_in = 1'(l);
      end else begin
        l = 0;
        unit_out_valid = 1'b0;
      end
      #1;
      check("rr_lane_ready", 128'(lane_ready), 128'(onehot(exp_order[k])));
      check("rr_operands", 128'(unit_operands), opnd(exp_order[k]));
      if (k > 0) begin
        check("rr_lane_out_valid", 128'(lane_out_valid), 128'(onehot(l)));
        check("rr_result", 128'(lane_result), 128'(res(l)));
      end
      if (k < 4)
        for (int i = 0; i < int'(NL); i++) if (lane_ready[i]) ready_cnt[i]++;
      sb.push_back(exp_order[k]);
      tick();
    end
    for (int i = 0; i < int'(NL); i++) check("rr_pulse_once", 128'(ready_cnt[i]), 128'(1));
    lane_valid = '0; unit_ready = 1'b0;
    return_one("rr_last");
    tick();
    unit_out_valid = 1'b0; #1;
    check("final_busy", 128'(busy), 128'(0));
    check("final_unit_out_ready", 128'(unit_out_ready), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
